// File: rtl/eth_mii_pkg.sv
// Shared constants and state encoding for the MII transmit framer.
// The optional FCS state exists only when ETH_TX_FCS_EN is defined.
package eth_mii_pkg;

  localparam logic [3:0]  PREAMBLE_NIBBLE = 4'h5;
  localparam logic [3:0]  SFD_NIBBLE      = 4'hD;
  localparam int unsigned PREAMBLE_LEN    = 15;

  localparam logic [31:0] CRC32_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SFD,
    ST_DATA_LO,
    ST_DATA_HI,
`ifdef ETH_TX_FCS_EN
    ST_FCS,
`endif
    ST_DROP,
    ST_IFG
  } tx_state_t;

endpackage

// File: rtl/eth_mii_tx_framer_crc.sv
// Combinational CRC-32 (reflected, LSB-first) advance by one byte.
// Ports: crc_in current CRC, data byte, crc_out CRC after the byte.
module eth_crc32_byte
  import eth_mii_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  // Bit-serial LFSR unrolled over the eight data bits, LSB first.
  always_comb begin
    crc_out = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (crc_out[0] ^ data[i]) crc_out = (crc_out >> 1) ^ CRC32_POLY;
      else                      crc_out = crc_out >> 1;
    end
  end

endmodule

// File: rtl/eth_mii_tx_framer.sv
// MII transmit framer: preamble, SFD, payload nibbles (low nibble first),
// optional CRC-32 FCS, then inter-frame gap.
// Macro ETH_TX_FCS_EN: when defined, FCS is generated and appended.
// Ports:
//   eth_mac_clock, eth_mac_rstn  clock, async active-low reset
//   s_tdata/s_tvalid/s_tlast     byte stream in; s_tready accept (comb)
//   eth_mii_txd, eth_mii_tx_en   registered MII TX pins
//   tx_busy                      not IDLE
//   tx_underrun                  one-cycle pulse on mid-frame starvation
module eth_mii_tx_framer
  import eth_mii_pkg::*;
#(
  parameter int unsigned IFG_NIBBLES = 24
) (
  input  logic       eth_mac_clock,
  input  logic       eth_mac_rstn,
  input  logic [7:0] s_tdata,
  input  logic       s_tvalid,
  input  logic       s_tlast,
  output logic       s_tready,
  output logic [3:0] eth_mii_txd,
  output logic       eth_mii_tx_en,
  output logic       tx_busy,
  output logic       tx_underrun
);

  localparam int unsigned     IFG_W    = $clog2(IFG_NIBBLES + 1);
  localparam logic [IFG_W-1:0] IFG_LAST = IFG_W'(IFG_NIBBLES - 1);
  localparam logic [3:0]      PRE_LAST = 4'(PREAMBLE_LEN - 1);

  tx_state_t        state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [IFG_W-1:0] ifg_q, ifg_d;
  logic [3:0]       hi_q;
  logic             last_q;
  logic             load;
  logic [3:0]       txd_d;
  logic             tx_en_d;
  logic             underrun_d;

`ifdef ETH_TX_FCS_EN
  logic [31:0] crc_q, crc_next, fcs;

  eth_crc32_byte u_crc (
    .crc_in  (crc_q),
    .data    (s_tdata),
    .crc_out (crc_next)
  );

  assign fcs = ~crc_q;

  // CRC restarts between frames; IFG included since IFG may chain straight into a preamble.
  always_ff @(posedge eth_mac_clock or negedge eth_mac_rstn) begin
    if (!eth_mac_rstn) begin
      crc_q <= CRC32_INIT;
    end else if (state_q == ST_IDLE || state_q == ST_IFG) begin
      crc_q <= CRC32_INIT;
    end else if (load) begin
      crc_q <= crc_next;
    end
  end
`endif

  assign tx_busy = (state_q != ST_IDLE);

  // State, counters, held byte and registered pins.
  always_ff @(posedge eth_mac_clock or negedge eth_mac_rstn) begin
    if (!eth_mac_rstn) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      ifg_q         <= '0;
      hi_q          <= '0;
      last_q        <= 1'b0;
      eth_mii_txd   <= '0;
      eth_mii_tx_en <= 1'b0;
      tx_underrun   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ifg_q         <= ifg_d;
      eth_mii_txd   <= txd_d;
      eth_mii_tx_en <= tx_en_d;
      tx_underrun   <= underrun_d;
      if (load) begin
        hi_q   <= s_tdata[7:4];
        last_q <= s_tlast;
      end
    end
  end

  // Next state; pin values are computed for the state being entered.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ifg_d      = ifg_q;
    load       = 1'b0;
    s_tready   = 1'b0;
    txd_d      = '0;
    tx_en_d    = 1'b0;
    underrun_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (s_tvalid) begin
          state_d = ST_PREAMBLE;
          cnt_d   = '0;
          txd_d   = PREAMBLE_NIBBLE;
          tx_en_d = 1'b1;
        end
      end
      ST_PREAMBLE: begin
        tx_en_d = 1'b1;
        if (cnt_q == PRE_LAST) begin
          state_d = ST_SFD;
          txd_d   = SFD_NIBBLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
          txd_d = PREAMBLE_NIBBLE;
        end
      end
      ST_SFD: begin
        s_tready = 1'b1;
        if (s_tvalid) begin
          load    = 1'b1;
          state_d = ST_DATA_LO;
          txd_d   = s_tdata[3:0];
          tx_en_d = 1'b1;
        end else begin
          underrun_d = 1'b1;
          state_d    = ST_DROP;
        end
      end
      ST_DATA_LO: begin
        state_d = ST_DATA_HI;
        txd_d   = hi_q;
        tx_en_d = 1'b1;
      end
      ST_DATA_HI: begin
        if (last_q) begin
`ifdef ETH_TX_FCS_EN
          state_d = ST_FCS;
          cnt_d   = '0;
          txd_d   = fcs[3:0];
          tx_en_d = 1'b1;
`else
          state_d = ST_IFG;
          ifg_d   = '0;
`endif
        end else begin
          s_tready = 1'b1;
          if (s_tvalid) begin
            load    = 1'b1;
            state_d = ST_DATA_LO;
            txd_d   = s_tdata[3:0];
            tx_en_d = 1'b1;
          end else begin
            underrun_d = 1'b1;
            state_d    = ST_DROP;
          end
        end
      end
`ifdef ETH_TX_FCS_EN
      ST_FCS: begin
        if (cnt_q == 4'd7) begin
          state_d = ST_IFG;
          ifg_d   = '0;
        end else begin
          cnt_d   = cnt_q + 4'd1;
          txd_d   = fcs[{cnt_d[2:0], 2'b00} +: 4];
          tx_en_d = 1'b1;
        end
      end
`endif
      ST_DROP: begin
        s_tready = 1'b1;
        if (s_tvalid && s_tlast) begin
          state_d = ST_IFG;
          ifg_d   = '0;
        end
      end
      ST_IFG: begin
        // A pending frame chains directly into its preamble so the gap is exactly IFG_NIBBLES.
        if (ifg_q == IFG_LAST) begin
          if (s_tvalid) begin
            state_d = ST_PREAMBLE;
            cnt_d   = '0;
            txd_d   = PREAMBLE_NIBBLE;
            tx_en_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          ifg_d = ifg_q + IFG_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_eth_mii_tx_framer.sv
// Self-checking bench for eth_mii_tx_framer (directed vectors + corner sequences).
module tb_eth_mii_tx_framer;

  localparam int IFG = 24;
`ifdef ETH_TX_FCS_EN
  localparam int FCS_N = 8;
`else
  localparam int FCS_N = 0;
`endif

  logic       eth_mac_clock;
  logic       eth_mac_rstn;
  logic [7:0] s_tdata;
  logic       s_tvalid;
  logic       s_tlast;
  logic       s_tready;
  logic [3:0] eth_mii_txd;
  logic       eth_mii_tx_en;
  logic       tx_busy;
  logic       tx_underrun;

  eth_mii_tx_framer #(.IFG_NIBBLES(IFG)) dut (
    .eth_mac_clock (eth_mac_clock),
    .eth_mac_rstn  (eth_mac_rstn),
    .s_tdata       (s_tdata),
    .s_tvalid      (s_tvalid),
    .s_tlast       (s_tlast),
    .s_tready      (s_tready),
    .eth_mii_txd   (eth_mii_txd),
    .eth_mii_tx_en (eth_mii_tx_en),
    .tx_busy       (tx_busy),
    .tx_underrun   (tx_underrun)
  );

  initial eth_mac_clock = 1'b0;
  always #5 eth_mac_clock = ~eth_mac_clock;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Per-cycle trace sampled on the falling edge.
  logic       rec = 1'b0;
  logic       en_tr[$];
  logic       rdy_tr[$];
  logic       busy_tr[$];
  logic       und_tr[$];
  logic [3:0] d_tr[$];
  int         und_cnt = 0;

  always @(negedge eth_mac_clock) begin
    if (rec) begin
      en_tr.push_back(eth_mii_tx_en);
      rdy_tr.push_back(s_tready);
      busy_tr.push_back(tx_busy);
      und_tr.push_back(tx_underrun);
      d_tr.push_back(eth_mii_txd);
      if (tx_underrun === 1'b1) und_cnt++;
    end
  end

  task automatic trace_clear();
    en_tr.delete(); rdy_tr.delete(); busy_tr.delete(); und_tr.delete(); d_tr.delete();
    und_cnt = 0;
  endtask

  task automatic find_seg(input int from, output int st, output int len);
    st = -1;
    len = 0;
    for (int i = from; i < en_tr.size(); i++) begin
      if (en_tr[i] === 1'b1) begin
        if (st < 0) st = i;
        len++;
      end else if (st >= 0) begin
        break;
      end
    end
  endtask

  // Checks tx_en length, 15x5 + D preamble and up to 8 payload nibbles (first nibble in [31:28]).
  task automatic check_frame(input string name, input int st_in, input int len, input int nnib,
                             input int exp_len, input logic [31:0] exp_nibs);
    int st;
    logic pre_ok;
    logic [31:0] act;
    st = (st_in < 0) ? 0 : st_in;
    chk({name, " en_len"}, 32'(len), 32'(exp_len));
    pre_ok = 1'b1;
    for (int i = 0; i < 15; i++) if (d_tr[st+i] !== 4'h5) pre_ok = 1'b0;
    if (d_tr[st+15] !== 4'hD) pre_ok = 1'b0;
    chk({name, " preamble"}, 32'(pre_ok), 32'd1);
    act = '0;
    for (int i = 0; i < nnib; i++) act[31-4*i -: 4] = d_tr[st+16+i];
    chk({name, " payload"}, act, exp_nibs);
  endtask

  // Byte i of the frame is data[8i+:8]; before byte 'gap' valid is held low for two cycles.
  task automatic send(input logic [127:0] data, input int n, input int gap, output bit ok);
    int k;
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (i == gap) begin
        s_tvalid = 1'b0;
        repeat (2) @(posedge eth_mac_clock);
        #1;
      end
      s_tvalid = 1'b1;
      s_tdata  = data[8*i +: 8];
      s_tlast  = (i == n - 1);
      k = 0;
      @(negedge eth_mac_clock);
      while (s_tready !== 1'b1 && k < 200) begin
        @(negedge eth_mac_clock);
        k++;
      end
      if (k >= 200) begin
        ok = 1'b0;
        break;
      end
      @(posedge eth_mac_clock);
      #1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    @(negedge eth_mac_clock);
    while (tx_busy !== 1'b0 && k < 500) begin
      @(negedge eth_mac_clock);
      k++;
    end
    chk({name, " reaches idle"}, 32'(tx_busy), 32'd0);
  endtask

  typedef struct {
    logic [31:0] data;
    int          n;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[4];
  int   st, len, st2, len2, cnt;
  bit   ok, ok2;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Frames (byte 0 in bits [7:0]) and their expected payload nibbles in wire order.
    vecs[0] = '{32'h0000_3412, 2, 32'h2143_0000};
    vecs[1] = '{32'h0000_00A5, 1, 32'h5A00_0000};
    vecs[2] = '{32'h000F_FF00, 3, 32'h00FF_F000};
    vecs[3] = '{32'hEFBE_ADDE, 4, 32'hEDDA_EBFE};

    eth_mac_rstn = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tlast  = 1'b0;
    repeat (3) @(negedge eth_mac_clock);
    chk("reset txd", 32'(eth_mii_txd), 32'd0);
    chk("reset tx_en", 32'(eth_mii_tx_en), 32'd0);
    chk("reset s_tready", 32'(s_tready), 32'd0);
    chk("reset tx_busy", 32'(tx_busy), 32'd0);
    chk("reset tx_underrun", 32'(tx_underrun), 32'd0);
    eth_mac_rstn = 1'b1;
    repeat (2) @(negedge eth_mac_clock);

    // Table-driven frames.
    for (int v = 0; v < 4; v++) begin
      trace_clear();
      rec = 1'b1;
      if (v == 0) begin
        @(posedge eth_mac_clock);
        #1;
        s_tvalid = 1'b1;
        s_tdata  = vecs[v].data[7:0];
        s_tlast  = 1'b0;
        @(negedge eth_mac_clock);
        chk("latency idle tx_en", 32'(eth_mii_tx_en), 32'd0);
        chk("latency idle s_tready", 32'(s_tready), 32'd0);
        @(negedge eth_mac_clock);
        chk("latency first nibble en", 32'(eth_mii_tx_en), 32'd1);
        chk("latency first nibble txd", 32'(eth_mii_txd), 32'h5);
      end
      send(128'(vecs[v].data), vecs[v].n, -1, ok);
      chk($sformatf("vec%0d handshake", v), 32'(ok), 32'd1);
      wait_idle($sformatf("vec%0d", v));
      rec = 1'b0;
      find_seg(0, st, len);
      check_frame($sformatf("vec%0d", v), st, len, 2 * vecs[v].n, 16 + 2 * vecs[v].n + FCS_N, vecs[v].exp);
      chk($sformatf("vec%0d no underrun", v), 32'(und_cnt), 32'd0);
    end

`ifdef ETH_TX_FCS_EN
    // "123456789" -> FCS 0xCBF43926 sent LS nibble first.
    trace_clear();
    rec = 1'b1;
    send(128'h39_38_37_36_35_34_33_32_31, 9, -1, ok);
    chk("fcs handshake", 32'(ok), 32'd1);
    wait_idle("fcs");
    rec = 1'b0;
    find_seg(0, st, len);
    check_frame("fcs", st, len, 8, 16 + 18 + 8, 32'h1323_3343);
    begin
      logic [31:0] fcs_act;
      fcs_act = '0;
      for (int i = 0; i < 8; i++) fcs_act[31-4*i -: 4] = d_tr[st+34+i];
      chk("fcs nibbles", fcs_act, 32'h6293_4FBC);
    end
`endif

    // Back-to-back 1-byte frames with valid held high across the gap.
    trace_clear();
    rec = 1'b1;
    send(128'h11, 1, -1, ok);
    send(128'h22, 1, -1, ok2);
    chk("b2b handshake", 32'(ok & ok2), 32'd1);
    wait_idle("b2b");
    rec = 1'b0;
    find_seg(0, st, len);
    find_seg(st + len, st2, len2);
    check_frame("b2b f1", st, len, 2, 18 + FCS_N, 32'h1100_0000);
    chk("b2b gap", 32'(st2 - (st + len)), 32'(IFG));
    check_frame("b2b f2", st2, len2, 2, 18 + FCS_N, 32'h2200_0000);
    cnt = 0;
    for (int i = st + len; i < st2 + 15; i++) if (rdy_tr[i] !== 1'b0 || busy_tr[i] !== 1'b1) cnt++;
    chk("b2b ready low while busy", 32'(cnt), 32'd0);
    chk("b2b ready at sfd", 32'(rdy_tr[st2+15]), 32'd1);

    // Underrun: byte 2 not available at the HI phase of byte 1.
    trace_clear();
    rec = 1'b1;
    send(128'h04_03_02_01, 4, 2, ok);
    chk("underrun bytes consumed", 32'(ok), 32'd1);
    wait_idle("underrun");
    rec = 1'b0;
    find_seg(0, st, len);
    check_frame("underrun", st, len, 4, 20, 32'h1020_0000);
    chk("underrun pulse count", 32'(und_cnt), 32'd1);
    chk("underrun pulse position", 32'(und_tr[st+len]), 32'd1);
    find_seg(st + len, st2, len2);
    chk("underrun no further tx_en", 32'(len2), 32'd0);
    cnt = 0;
    for (int i = st + len; i < busy_tr.size() && busy_tr[i] === 1'b1; i++) cnt++;
    chk("underrun drop+ifg cycles", 32'(cnt), 32'(2 + IFG));

    // Reset asserted during DATA, then a fresh frame.
    s_tvalid = 1'b1;
    s_tdata  = 8'h55;
    s_tlast  = 1'b0;
    repeat (20) @(negedge eth_mac_clock);
    chk("midframe tx_en before reset", 32'(eth_mii_tx_en), 32'd1);
    s_tvalid = 1'b0;
    eth_mac_rstn = 1'b0;
    #1;
    chk("async reset txd", 32'(eth_mii_txd), 32'd0);
    chk("async reset tx_en", 32'(eth_mii_tx_en), 32'd0);
    chk("async reset tx_busy", 32'(tx_busy), 32'd0);
    chk("async reset tx_underrun", 32'(tx_underrun), 32'd0);
    repeat (3) @(negedge eth_mac_clock);
    eth_mac_rstn = 1'b1;
    @(negedge eth_mac_clock);
    trace_clear();
    rec = 1'b1;
    send(128'h3C, 1, -1, ok);
    chk("post-reset handshake", 32'(ok), 32'd1);
    wait_idle("post-reset");
    rec = 1'b0;
    find_seg(0, st, len);
    check_frame("post-reset", st, len, 2, 18 + FCS_N, 32'hC300_0000);
    chk("post-reset no underrun", 32'(und_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
